// File: rtl/ecc_ff_div.sv
// GF(2^m) field divider q = a / b mod f(z), binary extended Euclid, one reduction step per cycle.
// Optional macro ECC_FF_DIV_CYCLE_CNT_EN adds a cyc_cnt port holding the latency of the last operation.
module ecc_ff_div #(
   parameter int          m    = 163,
   parameter logic [m-1:0] POLY = 163'h0_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [m-1:0] a,
   input  logic [m-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [m-1:0] q,
   output logic         err
`ifdef ECC_FF_DIV_CYCLE_CNT_EN
   ,
   output logic [$clog2(4*m+3)-1:0] cyc_cnt
`endif
);

   localparam int         DW  = $clog2(m + 1);
   localparam logic [m:0] F   = {1'b1, POLY};
   localparam logic [m:0] ONE = {{m{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t       state, state_nxt;
   logic [m:0]   u, v, g1, g2;
   logic [m:0]   u_nxt, v_nxt, g1_nxt, g2_nxt;
   logic         zero_div, zero_div_nxt;
   logic         busy_nxt, done_nxt, err_nxt;
   logic [m-1:0] q_nxt;
   logic         accept;

   // Leading-one position over the full (m+1)-bit word.
   function automatic logic [DW-1:0] deg_of(input logic [m:0] x);
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i <= m; i++) begin
         if (x[i]) d = DW'(i);
      end
      return d;
   endfunction

   // Divide by z modulo f: an odd value gets f added first so the shift is exact.
   function automatic logic [m:0] half(input logic [m:0] x);
      return x[0] ? ((x ^ F) >> 1) : (x >> 1);
   endfunction

   // done is high while back in IDLE, so a start during the done cycle must be blocked here.
   assign accept = (state == IDLE) && start && !done;

   always_comb begin
      state_nxt    = state;
      u_nxt        = u;
      v_nxt        = v;
      g1_nxt       = g1;
      g2_nxt       = g2;
      zero_div_nxt = zero_div;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      q_nxt        = q;
      err_nxt      = err;
      case (state)
         IDLE: begin
            if (accept) begin
               busy_nxt = 1'b1;
               if (b == '0) begin
                  zero_div_nxt = 1'b1;
                  state_nxt    = FIN;
               end else begin
                  zero_div_nxt = 1'b0;
                  u_nxt        = {1'b0, b};
                  v_nxt        = F;
                  g1_nxt       = {1'b0, a};
                  g2_nxt       = '0;
                  state_nxt    = RUN;
               end
            end
         end
         RUN: begin
            if (u == ONE || v == ONE) begin
               state_nxt = FIN;
            end else if (!u[0]) begin
               u_nxt  = u >> 1;
               g1_nxt = half(g1);
            end else if (!v[0]) begin
               v_nxt  = v >> 1;
               g2_nxt = half(g2);
            end else if (deg_of(u) > deg_of(v)) begin
               u_nxt  = u ^ v;
               g1_nxt = g1 ^ g2;
            end else begin
               v_nxt  = v ^ u;
               g2_nxt = g2 ^ g1;
            end
         end
         FIN: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            err_nxt   = zero_div;
            if (zero_div)      q_nxt = '0;
            else if (u == ONE) q_nxt = g1[m-1:0];
            else               q_nxt = g2[m-1:0];
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         u        <= '0;
         v        <= '0;
         g1       <= '0;
         g2       <= '0;
         zero_div <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         q        <= '0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         u        <= u_nxt;
         v        <= v_nxt;
         g1       <= g1_nxt;
         g2       <= g2_nxt;
         zero_div <= zero_div_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         q        <= q_nxt;
         err      <= err_nxt;
      end
   end

`ifdef ECC_FF_DIV_CYCLE_CNT_EN
   // Stops counting when busy drops with done, leaving the last latency visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cyc_cnt <= '0;
      else if (accept) cyc_cnt <= '0;
      else if (busy)   cyc_cnt <= cyc_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_ecc_ff_div.sv
// Directed-vector and reference-model bench for the GF(2^163) divider ecc_ff_div.
module tb_ecc_ff_div;

   localparam int           M       = 163;
   localparam logic [M-1:0] F_LOW   = 163'hC9;
   localparam logic [M:0]   F_FULL  = {1'b1, F_LOW};
   localparam int           LAT_MAX = 4*M + 2;
   localparam int           WAIT_MAX = 2000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [M-1:0] a = '0;
   logic [M-1:0] b = '0;
   logic         busy, done, err;
   logic [M-1:0] q;

   int n_cmp = 0;
   int n_bad = 0;

   ecc_ff_div #(.m(M), .POLY(F_LOW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .q(q), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [M-1:0] va;
      logic [M-1:0] vb;
      logic [M-1:0] exp_q;
      logic         exp_err;
      logic         lat_exact;
      int           lat_lim;
   } vec_t;

   // Independent shift-and-add multiplier used to validate quotients.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
      logic [M:0] r;
      r = '0;
      for (int i = M - 1; i >= 0; i--) begin
         r = r << 1;
         if (r[M]) r = r ^ F_FULL;
         if (y[i]) r = r ^ {1'b0, x};
      end
      return r[M-1:0];
   endfunction

   function automatic logic [M-1:0] rand_word();
      logic [191:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return w[M-1:0];
   endfunction

   task automatic check_vec(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_le(input string name, input int act, input int lim);
      n_cmp++;
      if (act > lim) begin
         n_bad++;
         $display("FAIL %s: got %0d expected at most %0d", name, act, lim);
      end
   endtask

   // Called at a negedge; returns at the negedge of the cycle in which done is high.
   // lat counts cycles from the start cycle to the done cycle.
   task automatic run_op(input logic [M-1:0] ta, input logic [M-1:0] tb_v,
                         output logic [M-1:0] rq, output logic rerr, output int lat);
      int guard;
      guard = 0;
      while ((busy || done) && guard < WAIT_MAX) begin
         @(negedge clk);
         guard++;
      end
      a     = ta;
      b     = tb_v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = ~ta;
      b     = ~tb_v;
      lat   = 1;
      while (!done && lat < WAIT_MAX) begin
         @(negedge clk);
         lat++;
      end
      check_bit("done_arrived", done, 1'b1);
      rq   = q;
      rerr = err;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vecs[11];
      logic [M-1:0] z162, z_inv, rq, ra, rb;
      logic         rerr;
      int           lat, n_done, guard;

      z162 = '0;
      z162[162] = 1'b1;
      z_inv = '0;
      z_inv[162] = 1'b1; z_inv[6] = 1'b1; z_inv[5] = 1'b1; z_inv[2] = 1'b1;

      vecs[0]  = '{163'h1,   163'h1,    163'h1,    1'b0, 1'b0, 4};
      vecs[1]  = '{163'h1,   163'h2,    z_inv,     1'b0, 1'b0, LAT_MAX};
      vecs[2]  = '{163'h0,   163'h1234, 163'h0,    1'b0, 1'b0, LAT_MAX};
      vecs[3]  = '{163'h5A3, 163'h5A3,  163'h1,    1'b0, 1'b0, LAT_MAX};
      vecs[4]  = '{163'h123, 163'h0,    163'h0,    1'b1, 1'b1, 2};
      vecs[5]  = '{163'h3,   163'h1,    163'h3,    1'b0, 1'b0, LAT_MAX};
      vecs[6]  = '{163'h5,   163'h3,    163'h3,    1'b0, 1'b0, LAT_MAX};
      vecs[7]  = '{F_LOW,    163'h2,    z162,      1'b0, 1'b0, LAT_MAX};
      vecs[8]  = '{F_LOW,    z162,      163'h2,    1'b0, 1'b0, LAT_MAX};
      vecs[9]  = '{z162,     163'h1,    z162,      1'b0, 1'b0, LAT_MAX};
      vecs[10] = '{163'h0,   163'h0,    163'h0,    1'b1, 1'b1, 2};

      repeat (3) @(negedge clk);
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_done", done, 1'b0);
      check_bit("reset_err", err, 1'b0);
      check_vec("reset_q", q, '0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].va, vecs[i].vb, rq, rerr, lat);
         check_vec($sformatf("vec%0d_q", i), rq, vecs[i].exp_q);
         check_bit($sformatf("vec%0d_err", i), rerr, vecs[i].exp_err);
         if (vecs[i].lat_exact) check_int($sformatf("vec%0d_lat", i), lat, vecs[i].lat_lim);
         else                   check_le($sformatf("vec%0d_lat", i), lat, vecs[i].lat_lim);
         @(negedge clk);
         check_bit($sformatf("vec%0d_done_pulse", i), done, 1'b0);
         check_vec($sformatf("vec%0d_q_hold", i), q, vecs[i].exp_q);
      end

      for (int i = 0; i < 56; i++) begin
         ra = rand_word();
         rb = rand_word();
         if (ra == '0) ra = 163'h7;
         if (rb == '0) rb = 163'h9;
         run_op(ra, rb, rq, rerr, lat);
         check_vec($sformatf("rand%0d_qb", i), gf_mul(rq, rb), ra);
         check_bit($sformatf("rand%0d_err", i), rerr, 1'b0);
         check_le($sformatf("rand%0d_lat", i), lat, LAT_MAX);
      end

      // start held high through a whole operation with changing operands
      @(negedge clk);
      a = 163'h5; b = 163'h3; start = 1'b1;
      @(negedge clk);
      n_done = 0;
      guard = 0;
      while (!done && guard < WAIT_MAX) begin
         a = rand_word();
         b = rand_word() | 163'h1;
         @(negedge clk);
         guard++;
      end
      if (done) n_done++;
      check_int("spam_done_count", n_done, 1);
      check_vec("spam_q", q, 163'h3);
      check_bit("spam_err", err, 1'b0);
      a = 163'h123; b = 163'h0;
      @(negedge clk);
      check_bit("done_cycle_start_ignored_busy", busy, 1'b0);
      check_bit("done_cycle_start_ignored_done", done, 1'b0);
      a = F_LOW; b = 163'h2;
      @(negedge clk);
      start = 1'b0;
      check_bit("after_done_start_accepted", busy, 1'b1);
      guard = 0;
      while (!done && guard < WAIT_MAX) begin
         @(negedge clk);
         guard++;
      end
      check_bit("after_done_op_done", done, 1'b1);
      check_vec("after_done_op_q", q, z162);
      check_bit("after_done_op_err", err, 1'b0);

      // asynchronous abort 10 cycles into RUN
      run_op(163'h5, 163'h3, rq, rerr, lat);
      @(negedge clk);
      a = 163'h1; b = z162; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check_bit("abort_running", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check_bit("abort_busy", busy, 1'b0);
      check_bit("abort_done", done, 1'b0);
      check_vec("abort_q", q, '0);
      check_bit("abort_err", err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      repeat (800) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check_int("abort_no_done", n_done, 0);
      check_bit("abort_idle_busy", busy, 1'b0);
      run_op(163'h3, 163'h1, rq, rerr, lat);
      check_vec("post_abort_q", rq, 163'h3);
      check_bit("post_abort_err", rerr, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ecc_ff_div.md
Name: ecc_ff_div

Overview:
- Sequential GF(2^m) field divider: computes q = a / b mod f(z) in polynomial basis, using the binary extended Euclidean algorithm.
- It is the multiplicative-inverse counterpart of the combinational field adder ecc_ff_add, and supplies point-add/double slope computation and affine conversion in the ECC datapath.
- Operands and result use the same m-bit bus format as ecc_ff_add.

Parameters:
- m, 163, field degree; width of all operand/result buses.
- POLY, 163'h0_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9, low m bits of the reduction polynomial f. The z^m term is implicit. The default is the NIST B-163 polynomial z^163+z^7+z^6+z^3+1.

Ports:
- clk  input  1  system clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- a  input  m  dividend; captured on an accepted start.
- b  input  m  divisor; captured on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when q and err are valid.
- q  output  m  quotient; held stable from done until the next accepted start.
- err  output  1  set with done when b==0; held with q.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, err=0, q=0; internal registers cleared.
- If rst_n is asserted mid-operation, the operation is aborted immediately. No done is produced. After release the block accepts a new start.
- States: IDLE, RUN, FIN.
- IDLE, start=1 and b!=0: load u=b, v=f (m+1 bits), g1=a, g2=0; go to RUN.
- IDLE, start=1 and b==0: go to FIN with err=1 and result 0.
- RUN performs exactly one step per cycle, in priority order:
  - If u==1 or v==1: go to FIN.
  - Else if u[0]==0: u=u>>1; g1 = g1[0] ? (g1^f)>>1 : g1>>1.
  - Else if v[0]==0: same operation applied to v and g2.
  - Else if deg(u)>deg(v): u=u^v, g1=g1^g2.
  - Else: v=v^u, g2=g2^g1.
- g1/g2 arithmetic is m+1 bits wide. Results are always reduced below degree m.
- FIN (one cycle): q = (u==1) ? g1 : g2 (or 0 if err); done=1; busy=0; return to IDLE.
- Latency from start accept to done:
  - b==0: exactly 2 cycles.
  - Otherwise: at most 4*m+2 cycles. Every add step is followed by a shift, and total shifts are bounded by deg(b)+m ≤ 2m-1.
- start while busy=1 or in FIN is ignored, with no effect on the operation in progress.
- start in the same cycle done is high is ignored; the earliest accepted start is the cycle after done.
- a and b are don't-care after the accept cycle.
- deg() is evaluated with an (m+1)-bit leading-one priority encoder, combinational within the cycle.
- Inputs are assumed reduced: any m-bit value has degree < m. No masking is applied.

Optional Feature:
- Macro ECC_FF_DIV_CYCLE_CNT_EN.
- When defined: adds output port cyc_cnt, width $clog2(4*m+3).
  - Reset to 0 and cleared on an accepted start.
  - Increments once per cycle while busy.
  - Frozen at done, so it holds the latency of the last operation.
- When undefined: the port and counter are absent. Function and timing are otherwise identical.

Test Plan:
- a=1, b=1 -> done within 4 cycles of start; q=1, err=0.
- b=2 (z), a=1 -> q = z^-1 = z^162+z^6+z^5+z^2 (bits 162,6,5,2 set); err=0.
- 56 random nonzero pairs -> each q satisfies q*b mod f == a, checked against a reference model; every latency ≤ 4*m+2.
- a=0 with any nonzero b -> q=0. a=b=0x5A3 -> q=1. b=0, a=0x123 -> done 2 cycles after start; err=1, q=0.
- start pulsed every cycle during a RUN with different a/b -> exactly one done; q matches the first operands. A new start the cycle after done is accepted.
- rst_n pulled low 10 cycles into RUN -> busy=0, done=0, q=0 at once, with no done pulse after release. The next operation (a=3, b=1) -> q=3.
